// File: rtl/uart_rx_engine_if.sv
// uart_rx_engine_if: received-word handshake between the UART receive engine
// (master) and its consumer (slave).
interface uart_rx_engine_if;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       break_o;
  logic       overrun_o;

  modport master (
    output data_o,
    output valid_o,
    output parity_err_o,
    output frame_err_o,
    output break_o,
    output overrun_o,
    input  ready_i
  );

  modport slave (
    input  data_o,
    input  valid_o,
    input  parity_err_o,
    input  frame_err_o,
    input  break_o,
    input  overrun_o,
    output ready_i
  );
endinterface

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: oversampled UART receiver with per-frame configuration
// shadowing, parity/frame/break detection and a one-deep output register.
// Optional macro UART_RX_MAJORITY_EN: every bit sample becomes the 2-of-3
// majority of rxs one cycle before, at, and one cycle after the sample point.
module uart_rx_engine #(
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned CLK_DIV_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [CLK_DIV_W-1:0] cr_clk_div_i,
  input  logic [1:0]           cr_ds_i,
  input  logic [1:0]           cr_p_i,
  input  logic                 cr_s_i,
  input  logic                 uart_rx_i,
  uart_rx_engine_if.master     rx_if
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned BCNT_W  = 3;
  localparam int unsigned MIN_DIV = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   samp;

  logic [CLK_DIV_W-1:0]   cnt;
  logic [BCNT_W-1:0]      bit_cnt;
  logic                   stop2;
  logic [DATA_W-1:0]      shreg;
  logic                   par_acc;
  logic                   zero_acc;
  logic                   ferr_acc;

  logic [CLK_DIV_W-1:0]   div_q;
  logic [1:0]             ds_q;
  logic                   par_en_q;
  logic                   par_odd_q;
  logic                   two_stop_q;

  logic [CLK_DIV_W-1:0]   div_eff_c;
  logic [CLK_DIV_W-1:0]   half_c;
  logic                   post_c;
  logic [1:0]             align_c;
  logic [DATA_W-1:0]      post_data_c;
  logic                   post_perr_c;
  logic                   post_ferr_c;
  logic                   post_brk_c;

  // Input synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk_i) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  logic rxs_prev;
  logic rxs_next;

  // Previous rxs value; the next one is already waiting in the stage before rxs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) rxs_prev <= 1'b1;
    else         rxs_prev <= rxs;
  end

  assign rxs_next = sync_q[SYNC_STAGES-2];
  assign samp     = (rxs_prev & rxs) | (rxs_prev & rxs_next) | (rxs & rxs_next);
`else
  assign samp = rxs;
`endif

  // Clamp tiny dividers and derive the half-bit reload
  assign div_eff_c = (cr_clk_div_i < CLK_DIV_W'(MIN_DIV)) ? CLK_DIV_W'(MIN_DIV) : cr_clk_div_i;
  assign half_c    = (div_eff_c >> 1) - CLK_DIV_W'(1);

  // Final stop sample and the frame word/flags posted with it
  assign post_c      = (state == S_STOP) && (cnt == '0) && (!two_stop_q || stop2);
  assign align_c     = 2'd3 - ds_q;
  assign post_data_c = shreg >> align_c;
  assign post_perr_c = par_en_q && (par_odd_q ? !par_acc : par_acc);
  assign post_ferr_c = ferr_acc | !samp;
  assign post_brk_c  = two_stop_q ? zero_acc : (zero_acc & !samp);

  // Receive FSM: bit timing, shifting and status accumulation
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      stop2      <= 1'b0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      zero_acc   <= 1'b0;
      ferr_acc   <= 1'b0;
      div_q      <= '0;
      ds_q       <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            div_q      <= div_eff_c;
            ds_q       <= cr_ds_i;
            par_en_q   <= (cr_p_i == 2'b01) || (cr_p_i == 2'b10);
            par_odd_q  <= (cr_p_i == 2'b10);
            two_stop_q <= cr_s_i;
            cnt        <= half_c;
            state      <= S_START;
          end
        end
        S_START: begin
          if (cnt == '0) begin
            if (samp) begin
              state <= S_IDLE;
            end else begin
              state    <= S_DATA;
              cnt      <= div_q - CLK_DIV_W'(1);
              bit_cnt  <= '0;
              stop2    <= 1'b0;
              shreg    <= '0;
              par_acc  <= 1'b0;
              zero_acc <= 1'b1;
              ferr_acc <= 1'b0;
            end
          end else begin
            cnt <= cnt - CLK_DIV_W'(1);
          end
        end
        S_DATA: begin
          if (cnt == '0) begin
            shreg    <= {samp, shreg[DATA_W-1:1]};
            par_acc  <= par_acc ^ samp;
            zero_acc <= zero_acc & !samp;
            cnt      <= div_q - CLK_DIV_W'(1);
            if (bit_cnt == (BCNT_W'(4) + BCNT_W'(ds_q))) begin
              state <= par_en_q ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + BCNT_W'(1);
            end
          end else begin
            cnt <= cnt - CLK_DIV_W'(1);
          end
        end
        S_PARITY: begin
          if (cnt == '0) begin
            par_acc  <= par_acc ^ samp;
            zero_acc <= zero_acc & !samp;
            cnt      <= div_q - CLK_DIV_W'(1);
            state    <= S_STOP;
          end else begin
            cnt <= cnt - CLK_DIV_W'(1);
          end
        end
        S_STOP: begin
          if (cnt == '0) begin
            if (two_stop_q && !stop2) begin
              stop2    <= 1'b1;
              ferr_acc <= ferr_acc | !samp;
              zero_acc <= zero_acc & !samp;
              cnt      <= div_q - CLK_DIV_W'(1);
            end else begin
              state <= post_brk_c ? S_BREAK_WAIT : S_IDLE;
            end
          end else begin
            cnt <= cnt - CLK_DIV_W'(1);
          end
        end
        S_BREAK_WAIT: begin
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output register: post, hold until handshake, drop on overrun
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_if.valid_o      <= 1'b0;
      rx_if.data_o       <= '0;
      rx_if.parity_err_o <= 1'b0;
      rx_if.frame_err_o  <= 1'b0;
      rx_if.break_o      <= 1'b0;
      rx_if.overrun_o    <= 1'b0;
    end else begin
      rx_if.overrun_o <= 1'b0;
      if (post_c) begin
        if (rx_if.valid_o && !rx_if.ready_i) begin
          rx_if.overrun_o <= 1'b1;
        end else begin
          rx_if.valid_o      <= 1'b1;
          rx_if.data_o       <= post_data_c;
          rx_if.parity_err_o <= post_perr_c;
          rx_if.frame_err_o  <= post_ferr_c;
          rx_if.break_o      <= post_brk_c;
        end
      end else if (rx_if.valid_o && rx_if.ready_i) begin
        rx_if.valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_engine.md
UART_RX_ENGINE -- requirements
Module: uart_rx_engine

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 3, the number of uart_rx_i synchroniser flops (legal 2..4).
REQ-002 SHALL have parameter CLK_DIV_W, default 16, the width of the baud divider.
REQ-003 SHALL have port clk_i  in  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_ni  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port cr_clk_div_i  in  CLK_DIV_W  clk_i cycles per bit.
REQ-006 SHALL have port cr_ds_i  in  2  data bits = 5 + cr_ds_i.
REQ-007 SHALL have port cr_p_i  in  2  parity: 00 none, 01 even, 10 odd, 11 none.
REQ-008 SHALL have port cr_s_i  in  1  stop bits: 0 = one, 1 = two.
REQ-009 SHALL have port uart_rx_i  in  1  asynchronous serial line, idle high.
REQ-010 SHALL have port ready_i  in  1  consumer accepts data_o.
REQ-011 SHALL have port data_o  out  8  received word, LSB first on line, right-aligned, unused MSBs zero.
REQ-012 SHALL have ports valid_o, parity_err_o, frame_err_o, break_o  out  1 each  frame status, all qualified by valid_o.
REQ-013 SHALL have port overrun_o  out  1  one-cycle pulse when a frame is dropped.

Function
REQ-014 SHALL pass uart_rx_i through SYNC_STAGES flops reset to 1; the last stage is "rxs".
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
REQ-016 IDLE: when rxs==0, SHALL latch cr_* into shadow registers, load the half-bit counter with floor(div/2)-1, and go to START.
REQ-017 SHALL ignore cr_* changes mid-frame; only the shadow copies are used until the next IDLE.
REQ-018 SHALL treat any latched div below 4 as 4.
REQ-019 START: at the half-bit point, SHALL sample rxs; 1 -> back to IDLE with no output (glitch rejected); 0 -> DATA, bit counter loaded with div-1.
REQ-020 DATA: SHALL sample one bit every div cycles, shifting in LSB first, for 5+cr_ds bits, then go to PARITY if enabled, else STOP.
REQ-021 PARITY: SHALL sample one bit; parity_err = (XOR of data and parity bit) != 0 for even, == 0 for odd.
REQ-022 STOP: SHALL sample 1 or 2 stop bits; frame_err = 1 if any stop sample is 0.
REQ-023 break SHALL equal 1 when all data bits, the parity bit if present, and the first stop bit are 0.
REQ-024 On the final stop sample, SHALL go to BREAK_WAIT if break, else IDLE, and post the frame.
REQ-025 BREAK_WAIT: SHALL stay until rxs==1, then go to IDLE.
REQ-026 Posting SHALL make valid_o=1 with data_o and all flags updated on the next cycle; posting latency is 1 clk_i after the last stop sample.
REQ-027 valid_o SHALL hold, with data_o and flags stable, until a cycle with valid_o && ready_i, after which it deasserts.
REQ-028 Posting while valid_o=1 with ready_i=0: SHALL drop the new frame, keep the old one, and pulse overrun_o for 1 cycle.
REQ-029 Posting on the same cycle as a handshake: SHALL load the new frame, keep valid_o=1, and not raise overrun_o.
REQ-030 All counters SHALL be CLK_DIV_W bits and never wrap; they reload before reaching zero underflow.

Reset
REQ-031 rst_ni=0 at a clock edge SHALL force IDLE, synchroniser flops=1, counters=0, data_o=0, and all status outputs=0.
REQ-032 Reset mid-frame SHALL discard the partial frame; reception resumes only on the next falling edge of rxs after release.

Configuration
REQ-033 Macro UART_RX_MAJORITY_EN defined: each START, DATA, PARITY and STOP sample SHALL be the 2-of-3 majority of rxs at sample point -1, 0 and +1 cycle.
REQ-034 UART_RX_MAJORITY_EN undefined: each sample SHALL be the single rxs value at the sample point, with no extra logic.
REQ-035 Sample-point timing and all outputs other than the sampled values SHALL be identical in both builds.

Verification
REQ-036 div=16, ds=3, p=00, s=0, send 0xA5, ready_i=1 -> one valid_o cycle, data_o=0xA5, all flags 0.
REQ-037 div=16, ds=3, p=01, send 0x3C with parity bit 1 -> data_o=0x3C, parity_err_o=1; repeat with p=10 -> parity_err_o=0.
REQ-038 div=16, 6-cycle low pulse on an idle line -> no valid_o; then 0x55 sent -> data_o=0x55.
REQ-039 div=16, ready_i=0, send 0x11 then 0x22 -> data_o stays 0x11, overrun_o pulses once; ready_i=1 -> valid_o drops.
REQ-040 div=16, p=00, line low for 20 bit times then high -> data_o=0, frame_err_o=1, break_o=1; next frame 0x7E decodes only after the line returns high.
REQ-041 With UART_RX_MAJORITY_EN defined, a 1-cycle inverted glitch at the mid-bit of 0xF0 bit 4 -> data_o=0xF0; without the macro -> data_o=0xE0.
